// File: rtl/alu_operand_pkg.sv
// Shared definitions for the ALU operand select stages.
// State encoding and select-width helper.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } opState_e;

  function automatic int calcSelw(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/alu_operand_if.sv
// Producer/consumer bundle around the operand stage.
// The stage takes the slave side.
interface alu_operand_if
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC = 4,
  localparam int SELW = calcSelw(NSRC)
) ();

  logic [NSRC*WIDTH-1:0] src_flat;
  logic [SELW-1:0]       sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_sel_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output src_flat, sel, in_valid,
    output flush, out_ready,
    input  in_ready, out_data,
    input  out_sel_err, out_valid
  );

  modport slave (
    input  src_flat, sel, in_valid,
    input  flush, out_ready,
    output in_ready, out_data,
    output out_sel_err, out_valid
  );

endinterface

// File: rtl/alu_operand_stage_mux.sv
// N-way operand select; out-of-range selects
// yield zero data with selErr set.
module operand_mux_n
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC = 4,
  localparam int SELW = calcSelw(NSRC)
) (
  input  logic [NSRC*WIDTH-1:0] srcFlat,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      data,
  output logic                  selErr
);

  always_comb begin
    data   = '0;
    selErr = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SELW'(i)) begin
        data   = srcFlat[i*WIDTH +: WIDTH];
        selErr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand select with a 2-entry
// skid buffer so the ALU can stall freely.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NSRC = 4
) (
  input logic           clk,
  input logic           reset,
  alu_operand_if.slave  bus
);

  opState_e         state;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic [WIDTH-1:0] muxData;
  logic             mainErr;
  logic             skidErr;
  logic             muxErr;
  logic             acc;
  logic             pop;

  operand_mux_n #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC)
  ) uMux (
    .srcFlat (bus.src_flat),
    .sel     (bus.sel),
    .data    (muxData),
    .selErr  (muxErr)
  );

  // Handshake flags come only from registered state.
  assign bus.in_ready    = (state != ST_FULL);
  assign bus.out_valid   = (state != ST_EMPTY);
  assign bus.out_data    = mainData;
  assign bus.out_sel_err = mainErr;

  assign acc = bus.in_valid & bus.in_ready;
  assign pop = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      mainData <= '0;
      mainErr  <= 1'b0;
      skidData <= '0;
      skidErr  <= 1'b0;
    end else if (bus.flush) begin
      state <= ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc) begin
            mainData <= muxData;
            mainErr  <= muxErr;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            mainData <= muxData;
            mainErr  <= muxErr;
          end else if (acc) begin
            skidData <= muxData;
            skidErr  <= muxErr;
            state    <= ST_FULL;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            mainData <= skidData;
            mainErr  <= skidErr;
            state    <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised, registered successor to the ALUSrcB 4:1 operand select.
- Selects one of NSRC WIDTH-bit sources and flags out-of-range selects.
- Holds the result in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Sits between the register/immediate datapath and the ALU, so the ALU can stall without losing an operand.
- Sustains one operand per cycle with one cycle of latency.

## Interface

Parameters:
- WIDTH, 32, operand width in bits (≥1)
- NSRC, 4, number of selectable sources (2..16)
- SELW, derived localparam, max(1, ceil(log2(NSRC))); not overridable

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; asserting clears all state immediately, release is synchronised by the integrator
- src_flat  in  NSRC*WIDTH  source i at bits [i*WIDTH +: WIDTH]
- sel  in  SELW  source index; values ≥ NSRC are illegal
- in_valid  in  1  producer has an operand request this cycle
- in_ready  out  1  stage can accept; equals NOT skid_valid (registered, no combinational path from out_ready)
- flush  in  1  synchronous discard of all held entries
- out_data  out  WIDTH  selected operand at head of buffer
- out_sel_err  out  1  head entry came from an illegal sel; travels with its data
- out_valid  out  1  head entry valid
- out_ready  in  1  ALU consumes head this cycle

## Operation

- Select: legal sel → src_flat slice; illegal sel → data 32'b0-equivalent (all zeros, WIDTH bits) and sel_err=1 for that entry. The entry is still accepted and delivered, never dropped.
- Accept when in_valid & in_ready; pop when out_valid & out_ready.
- States (2-bit, from entry count):
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Transitions (acc=accept, pop=pop):
  - EMPTY: acc → ONE (load main).
  - ONE: acc & pop → ONE (load main). acc & !pop → FULL (load skid). !acc & pop → EMPTY.
  - FULL: in_ready=0, so no acc. pop → ONE (skid moves into main, skid cleared). !pop → FULL, all held.
- Ordering is strict FIFO; the skid entry is never presented before main.
- flush=1: next state EMPTY.
  - Takes priority over a same-cycle accept; the input offered that cycle is dropped.
  - Takes priority over a pop; a head popped that cycle counts as consumed.
- out_data and out_sel_err hold their last value while out_valid=0; they are don't-care to consumers.
- Held data is stable while out_valid=1 and out_ready=0. A test bench asserts this.

## Timing

- Reset values:
  - out_valid=0, out_data=0, out_sel_err=0, state=EMPTY.
  - in_ready=1 during and after reset.
- Latency: accept at edge N → out_valid=1 with that data from edge N onward. This is one register stage. There is no combinational in→out path.
- Throughput: 1 entry/cycle while out_ready=1.
- Back-pressure:
  - out_ready low for one cycle while in_valid is continuous → FULL, in_ready=0 the next cycle.
  - No entry is lost or duplicated.
- in_ready depends only on registered state.
- Reset asserted mid-transfer: all entries are lost, and outputs go to reset values asynchronously, without waiting for an edge.

## Structure

- Shared package alu_operand_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
  - the SELW computation function
  - The next ALUSrcA stage reuses both.
- One natural sub-module: operand_mux_n (combinational, parametrised WIDTH/NSRC). Outputs data and sel_err; instantiated once.
- Skid/state logic lives in the top module. Target size 150–250 RTL lines.

## Test plan

- Reset then single transfer: WIDTH=32, NSRC=4, src2=32'hDEADBEEF, sel=2, one in_valid pulse, out_ready=1. Required: out_data=DEADBEEF, out_valid high exactly 1 cycle, sel_err=0.
- Illegal select: NSRC=3, sel=3, src0..2 nonzero. Required: out_data=0, out_sel_err=1, and the entry is still delivered.
- Back-pressure: stream values 1,2,3,4 continuously; out_ready=0 during cycles 2–4. Required: in_ready=0 while FULL, output order 1,2,3,4 with no loss, out_data stable while stalled.
- Flush: hold FULL with 5,6 and assert flush with in_valid=1, data 7. Required: next cycle out_valid=0, in_ready=1, and 7 is never delivered.
- Async reset mid-stall: in FULL, drop reset between edges. Required: out_valid=0 immediately, in_ready=1; after release, a fresh transfer of 32'hA5A5A5A5 passes with 1-cycle latency.
- Parameter sweep: WIDTH=8/NSRC=2 and WIDTH=64/NSRC=16, with random sel/valid/ready for 10k cycles. Check against a scoreboard model: order kept, no loss or duplication, and sel_err set iff sel≥NSRC.
